// File: rtl/equ_div_scheduler.sv
// rtl/equ_div_scheduler.sv - schedules one shared-divider operation per subcarrier for the equalizer
// Optional divider watchdog: define EQU_DIV_TIMEOUT_EN.
module equ_div_scheduler #(
  parameter int NUM_SC      = 12,
  parameter int PILOT_SYM   = 3,
  parameter int DATA_SYMS   = 6,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        i_clk_equ,
  input  logic        i_rst,
  input  logic        i_sym_valid,
  input  logic [2:0]  i_symbol_num,
  input  logic [11:0] i_est_done12,
  input  logic        i_div_done,
  output logic        o_start_div,
  output logic [3:0]  o_rd_add,
  output logic [2:0]  o_state_num,
  output logic        o_res_wr,
  output logic        o_done_equ_one_symbol,
  output logic        o_done_equ_7symbols,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_err_timeout
);

  localparam int SYM_W = (DATA_SYMS > 1) ? $clog2(DATA_SYMS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EST,
    ISSUE,
    WAIT_DIV,
    NEXT,
    SYM_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       sc;
  logic [SYM_W-1:0] sym_cnt;
  logic             sym_accept;
  logic             last_sc;
  logic             last_sym;
  logic             timeout;

  // The pilot symbol and index 7 are silently dropped while idle.
  assign sym_accept = (state == IDLE) && i_sym_valid &&
                      (i_symbol_num != 3'd7) && (i_symbol_num != 3'(PILOT_SYM));
  assign last_sc    = (sc == 4'(NUM_SC - 1));
  assign last_sym   = (sym_cnt == SYM_W'(DATA_SYMS - 1));

`ifdef EQU_DIV_TIMEOUT_EN
  localparam int WD_W = $clog2(DIV_TIMEOUT + 1);

  logic [WD_W-1:0] wd;

  // A result arriving in the final watchdog cycle still wins over the abort.
  assign timeout = (state == WAIT_DIV) && !i_div_done && (wd == WD_W'(DIV_TIMEOUT - 1));

  always_ff @(posedge i_clk_equ or posedge i_rst) begin
    if (i_rst) begin
      wd <= '0;
    end else if (state == WAIT_DIV) begin
      wd <= wd + 1'b1;
    end else begin
      wd <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk_equ or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (sym_accept) state_nxt = WAIT_EST;
      WAIT_EST: if (i_est_done12[sc]) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_DIV;
      WAIT_DIV: begin
        if (i_div_done) begin
          state_nxt = NEXT;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      NEXT:     state_nxt = last_sc ? SYM_DONE : WAIT_EST;
      SYM_DONE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_equ or posedge i_rst) begin
    if (i_rst) begin
      sc          <= '0;
      o_state_num <= '0;
      sym_cnt     <= '0;
    end else begin
      if (sym_accept) begin
        sc          <= '0;
        o_state_num <= i_symbol_num;
      end else if ((state == NEXT) && !last_sc) begin
        sc <= sc + 4'd1;
      end
      if (state == SYM_DONE) begin
        sym_cnt <= last_sym ? '0 : sym_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_start_div           = 1'b0;
    o_res_wr              = 1'b0;
    o_done_equ_one_symbol = 1'b0;
    o_done_equ_7symbols   = 1'b0;
    o_rd_add              = '0;
    o_busy                = (state != IDLE);
    unique case (state)
      IDLE: ;
      WAIT_EST, WAIT_DIV: o_rd_add = sc;
      ISSUE: begin
        o_rd_add    = sc;
        o_start_div = 1'b1;
      end
      NEXT: begin
        o_rd_add = sc;
        o_res_wr = 1'b1;
      end
      SYM_DONE: begin
        o_done_equ_one_symbol = 1'b1;
        o_done_equ_7symbols   = last_sym;
      end
      default: ;
    endcase
  end

  assign o_overrun     = i_sym_valid && (state != IDLE);
  assign o_err_timeout = timeout;

endmodule

// File: tb/tb_equ_div_scheduler.sv
// tb/tb_equ_div_scheduler.sv - self-checking bench for equ_div_scheduler
module tb_equ_div_scheduler;

  localparam int NUM_SC = 12;
  localparam int PILOT  = 3;
  localparam int D      = 4;
  localparam int DIV_TO = 64;
  localparam int MAXC   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sym_valid = 1'b0;
  logic [2:0]  symbol_num = 3'd0;
  logic [11:0] est = 12'hFFF;
  logic        div_done = 1'b0;
  logic        start_div, res_wr, done1, done7, busy, overrun, err_to;
  logic [3:0]  rd_add;
  logic [2:0]  state_num;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected per-cycle outputs, filled from timing arithmetic when a symbol is accepted.
  bit e_busy[MAXC];
  bit e_start[MAXC];
  bit e_wr[MAXC];
  bit e_done1[MAXC];
  bit e_done7[MAXC];
  bit e_ovr[MAXC];
  bit e_to[MAXC];
  int e_addr[MAXC];
  int e_snum[MAXC];
  int est_ready[NUM_SC];
  int nsym = 0;
  int end_cyc = 0;
  int abort_sc = -1;
  bit div_en = 1'b1;
  bit last_ovr = 1'b0;
  int n_start = 0;
  int n_done1 = 0;
  int pend[$];

  equ_div_scheduler #(
    .NUM_SC(12), .PILOT_SYM(3), .DATA_SYMS(6), .DIV_TIMEOUT(64)
  ) dut (
    .i_clk_equ(clk),
    .i_rst(rst),
    .i_sym_valid(sym_valid),
    .i_symbol_num(symbol_num),
    .i_est_done12(est),
    .i_div_done(div_done),
    .o_start_div(start_div),
    .o_rd_add(rd_add),
    .o_state_num(state_num),
    .o_res_wr(res_wr),
    .o_done_equ_one_symbol(done1),
    .o_done_equ_7symbols(done7),
    .o_busy(busy),
    .o_overrun(overrun),
    .o_err_timeout(err_to)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic set_busy(input int c, input int sym);
    e_busy[c] = 1'b1;
    e_snum[c] = sym;
  endtask

  // Per subcarrier: wait for estimate, one issue cycle, D cycles of division, one write cycle.
  task automatic plan_sym(input int c0, input int sym);
    int t, w;
    t = c0 + 1;
    for (int k = 0; k < NUM_SC; k++) begin
      w = (est_ready[k] > t) ? est_ready[k] : t;
      for (int c = t; c <= w + 1; c++) set_busy(c, sym);
      e_start[w+1] = 1'b1;
      e_addr[w+1]  = k;
      if (k == abort_sc) begin
        for (int c = w + 2; c <= w + 1 + DIV_TO; c++) set_busy(c, sym);
        e_to[w+1+DIV_TO] = 1'b1;
        end_cyc = w + 1 + DIV_TO;
        return;
      end
      for (int c = w + 2; c <= w + 2 + D; c++) set_busy(c, sym);
      e_wr[w+2+D]   = 1'b1;
      e_addr[w+2+D] = k;
      t = w + 3 + D;
    end
    set_busy(t, sym);
    e_done1[t] = 1'b1;
    nsym++;
    if (nsym == 6) begin
      e_done7[t] = 1'b1;
      nsym = 0;
    end
    end_cyc = t;
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_busy[c] = 1'b0; e_start[c] = 1'b0; e_wr[c] = 1'b0; e_done1[c] = 1'b0;
      e_done7[c] = 1'b0; e_ovr[c] = 1'b0; e_to[c] = 1'b0;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_sym(input int sym);
    int c;
    c = cyc;
    sym_valid  = 1'b1;
    symbol_num = 3'(sym);
    if (e_busy[c]) e_ovr[c] = 1'b1;
    else if (sym != PILOT && sym <= 6) plan_sym(c, sym);
    #3 last_ovr = overrun;
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  // Divider stand-in: answers D cycles after each launch, forgets everything on reset.
  initial forever begin
    @(negedge clk);
    #1;
    div_done = 1'b0;
    if (rst) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0] == cyc) begin
        div_done = 1'b1;
        void'(pend.pop_front());
      end
      if (start_div && div_en) pend.push_back(cyc + D);
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (cyc < MAXC) begin
      chk("start_div", int'(start_div), int'(e_start[cyc]));
      chk("res_wr", int'(res_wr), int'(e_wr[cyc]));
      chk("done_one", int'(done1), int'(e_done1[cyc]));
      chk("done_slot", int'(done7), int'(e_done7[cyc]));
      chk("busy", int'(busy), int'(e_busy[cyc]));
      chk("overrun", int'(overrun), int'(e_ovr[cyc]));
      chk("err_timeout", int'(err_to), int'(e_to[cyc]));
      if (e_start[cyc] || e_wr[cyc]) chk("rd_add", int'(rd_add), e_addr[cyc]);
      if (e_busy[cyc]) chk("state_num", int'(state_num), e_snum[cyc]);
      if (rst) begin
        chk("rst_rd_add", int'(rd_add), 0);
        chk("rst_state_num", int'(state_num), 0);
      end
      n_start += int'(start_div);
      n_done1 += int'(done1);
    end
  end

  initial begin
    #100000;
    $display("FAIL guard time expired cyc=%0d", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    int c0, c1, r, r2, s0, d0;
    for (int k = 0; k < NUM_SC; k++) est_ready[k] = 0;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_start", int'(start_div), 0);
    chk("reset_done", int'(done1), 0);
    chk("reset_rd_add", int'(rd_add), 0);
    @(negedge clk);

    // Full symbol, all estimates ready, accepted right after reset release.
    rst = 1'b0;
    c0 = cyc;
    s0 = n_start;
    pulse_sym(0);
    wait_until(c0 + 85);
    #3;
    chk("t1_done_at_85", int'(done1), 1);
    wait_until(c0 + 86);
    chk("t1_start_count", n_start - s0, 12);
    wait_until(end_cyc + 1);

    // Overrun while waiting on the divider.
    c0 = cyc;
    pulse_sym(1);
    wait_until(c0 + 5);
    pulse_sym(2);
    chk("t2_overrun_pulse", int'(last_ovr), 1);
    #3;
    chk("t2_state_num_kept", int'(state_num), 1);
    wait_until(end_cyc + 1);

    // Estimate stall at subcarrier 5, released later, then a second stall at 6.
    est = 12'h01F;
    c0 = cyc;
    r  = c0 + 1 + 5 * (D + 3) + 10;
    r2 = r + 20;
    est_ready[5] = r;
    for (int k = 6; k < NUM_SC; k++) est_ready[k] = r2;
    pulse_sym(4);
    wait_until(r - 1);
    #3;
    chk("t3_stall_rd_add", int'(rd_add), 5);
    chk("t3_stall_no_start", int'(start_div), 0);
    chk("t3_stall_busy", int'(busy), 1);
    wait_until(r);
    est = 12'h03F;
    wait_until(r + 1);
    #3;
    chk("t3_resume_start", int'(start_div), 1);
    wait_until(r2);
    est = 12'hFFF;
    wait_until(end_cyc + 1);
    for (int k = 0; k < NUM_SC; k++) est_ready[k] = 0;

    // Reset during the divide of subcarrier 7.
    c0 = cyc;
    pulse_sym(2);
    wait_until(c0 + 52);
    #3;
    chk("t4_pre_busy", int'(busy), 1);
    chk("t4_pre_rd_add", int'(rd_add), 7);
    wait_until(c0 + 53);
    rst = 1'b1;
    clear_from(cyc);
    nsym = 0;
    #3;
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_rd_add", int'(rd_add), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    c1 = cyc;
    pulse_sym(4);
    wait_until(c1 + 2);
    #3;
    chk("t4_restart_start", int'(start_div), 1);
    chk("t4_restart_rd_add", int'(rd_add), 0);
    wait_until(end_cyc + 1);

    // Full slot from a clean counter; index 7 and the pilot are ignored.
    rst = 1'b1;
    clear_from(cyc);
    nsym = 0;
    @(negedge clk);
    rst = 1'b0;
    pulse_sym(7);
    #3;
    chk("t5_idx7_ignored", int'(busy), 0);
    @(negedge clk);
    d0 = n_done1;
    for (int s = 0; s <= 6; s++) begin
      pulse_sym(s);
      if (s == PILOT) begin
        #3;
        chk("t5_pilot_ignored", int'(busy), 0);
        @(negedge clk);
      end else if (s == 6) begin
        wait_until(end_cyc);
        #3;
        chk("t5_slot_done", int'(done7), 1);
        chk("t5_last_sym_done", int'(done1), 1);
        wait_until(end_cyc + 1);
      end else begin
        wait_until(end_cyc + 1);
      end
    end
    chk("t5_done_count", n_done1 - d0, 6);

`ifdef EQU_DIV_TIMEOUT_EN
    // Divider never answers: watchdog aborts the symbol.
    div_en = 1'b0;
    abort_sc = 0;
    c0 = cyc;
    pulse_sym(0);
    abort_sc = -1;
    wait_until(c0 + 2 + DIV_TO);
    #3;
    chk("t6_timeout_pulse", int'(err_to), 1);
    wait_until(c0 + 3 + DIV_TO);
    #3;
    chk("t6_back_idle", int'(busy), 0);
    div_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
